// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, runs the imem req/ack handshake,
// hands words to decode and applies branch redirects resolved in execute.
//
// state | meaning
// IDLE  | first cycle after reset
// REQ   | request outstanding at pc
// HOLD  | fetched word presented to decode
// DRAIN | redirected while a request was in flight; wait for its ack
// HALT  | misaligned target seen; stopped until reset

`ifndef BRANCH_BASE_RS1
`define BRANCH_BASE_RS1 1'b1
`endif
`ifndef BRANCH_BASE_PC
`define BRANCH_BASE_PC 1'b0
`endif

module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        ex_valid,
    input  logic        branch_en,
    input  logic        branch_cond,
    input  logic        branch_base_sel,
    input  logic        branch_taken,
    input  logic [31:0] ex_pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] imm,
    output logic        flush,
    output logic        misalign
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] REQ   = 3'd1;
    localparam logic [2:0] HOLD  = 3'd2;
    localparam logic [2:0] DRAIN = 3'd3;
    localparam logic [2:0] HALT  = 3'd4;

    logic [2:0]  state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] instr_nxt, instr_pc_nxt;
    logic [31:0] base, target_raw, target;
    logic        sel_rs1, resolve, redirect, bad_target;

    assign sel_rs1    = (branch_base_sel == `BRANCH_BASE_RS1);
    assign base       = sel_rs1 ? rs1_data : ex_pc;
    assign target_raw = base + imm;
    // JALR clears bit 0 of the sum before the alignment check
    assign target     = {target_raw[31:1], target_raw[0] & ~sel_rs1};
    assign resolve    = ex_valid & branch_en & (~branch_cond | branch_taken);
    assign redirect   = resolve & ~target[1] & (state != HALT);
    assign bad_target = resolve &  target[1] & (state != HALT);

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        instr_nxt    = instr;
        instr_pc_nxt = instr_pc;
        case (state)
            IDLE: begin
                state_nxt = REQ;
                if (redirect) pc_nxt = target;
            end
            REQ: begin
                if (redirect) begin
                    pc_nxt    = target;
                    state_nxt = imem_ack ? REQ : DRAIN;
                end else if (imem_ack) begin
                    instr_nxt    = imem_rdata;
                    instr_pc_nxt = pc;
                    pc_nxt       = pc + 32'd4;
                    state_nxt    = HOLD;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_nxt    = target;
                    state_nxt = REQ;
                end else if (instr_ready) begin
                    state_nxt = REQ;
                end
            end
            DRAIN: begin
                if (redirect) pc_nxt = target;
                else if (imem_ack) state_nxt = REQ;
            end
            default: state_nxt = HALT;
        endcase
        if (bad_target) state_nxt = HALT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            instr_valid <= 1'b0;
            instr       <= 32'd0;
            instr_pc    <= 32'd0;
            flush       <= 1'b0;
            misalign    <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            imem_req    <= (state_nxt == REQ) || (state_nxt == DRAIN);
            // DRAIN keeps the stale address until the in-flight ack returns
            if (state_nxt == REQ) imem_addr <= pc_nxt;
            instr_valid <= (state_nxt == HOLD);
            instr       <= instr_nxt;
            instr_pc    <= instr_pc_nxt;
            flush       <= redirect;
            misalign    <= misalign | bad_target;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: sequential fetch, JAL/branch/JALR redirects,
// DRAIN behaviour, redirect-with-ack, misaligned target and reset restart.

`ifndef BRANCH_BASE_RS1
`define BRANCH_BASE_RS1 1'b1
`endif
`ifndef BRANCH_BASE_PC
`define BRANCH_BASE_PC 1'b0
`endif

module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        ex_valid;
    logic        branch_en;
    logic        branch_cond;
    logic        branch_base_sel;
    logic        branch_taken;
    logic [31:0] ex_pc;
    logic [31:0] rs1_data;
    logic [31:0] imm;
    logic        flush;
    logic        misalign;

    int total = 0;
    int bad   = 0;

    fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready),
        .ex_valid(ex_valid), .branch_en(branch_en), .branch_cond(branch_cond),
        .branch_base_sel(branch_base_sel), .branch_taken(branch_taken),
        .ex_pc(ex_pc), .rs1_data(rs1_data), .imm(imm),
        .flush(flush), .misalign(misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_resp(input int wait_n, input logic [31:0] data);
        for (int i = 0; i < wait_n; i++) step();
        imem_ack   = 1'b1;
        imem_rdata = data;
        step();
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
    endtask

    task automatic resolve_set(input logic cond, input logic taken, input logic sel,
                               input logic [31:0] epc, input logic [31:0] rs1,
                               input logic [31:0] off);
        ex_valid        = 1'b1;
        branch_en       = 1'b1;
        branch_cond     = cond;
        branch_taken    = taken;
        branch_base_sel = sel;
        ex_pc           = epc;
        rs1_data        = rs1;
        imm             = off;
    endtask

    task automatic resolve_clr();
        ex_valid  = 1'b0;
        branch_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'd0; instr_ready = 1'b0;
        ex_valid = 1'b0; branch_en = 1'b0; branch_cond = 1'b0;
        branch_base_sel = `BRANCH_BASE_PC; branch_taken = 1'b0;
        ex_pc = 32'd0; rs1_data = 32'd0; imm = 32'd0;
        step(); step();
        check("rst_req",   {31'd0, imem_req}, 32'd0);
        check("rst_addr",  imem_addr, 32'h0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_ipc",   instr_pc, 32'd0);
        check("rst_flush", {31'd0, flush}, 32'd0);
        check("rst_mis",   {31'd0, misalign}, 32'd0);

        // sequential fetch, one wait state, decode always ready
        rst = 1'b0; instr_ready = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            check("seq_req",  {31'd0, imem_req}, 32'd1);
            check("seq_addr", imem_addr, 32'(4 * i));
            mem_resp(1, 32'h1000_0013 + 32'(i));
            check("seq_valid", {31'd0, instr_valid}, 32'd1);
            check("seq_ipc",   instr_pc, 32'(4 * i));
            check("seq_instr", instr, 32'h1000_0013 + 32'(i));
            check("seq_flush", {31'd0, flush}, 32'd0);
            step();
        end
        check("seq_addr3", imem_addr, 32'hC);

        // JAL while holding
        instr_ready = 1'b0;
        mem_resp(0, 32'hAAAA_0001);
        check("jal_hold_ipc", instr_pc, 32'hC);
        resolve_set(1'b0, 1'b0, `BRANCH_BASE_PC, 32'h100, 32'h0, 32'h20);
        step();
        resolve_clr();
        check("jal_flush", {31'd0, flush}, 32'd1);
        check("jal_addr",  imem_addr, 32'h120);
        check("jal_valid", {31'd0, instr_valid}, 32'd0);
        step();
        check("jal_flush_end", {31'd0, flush}, 32'd0);
        check("jal_addr_hold", imem_addr, 32'h120);

        // conditional branch, not taken then taken with wrap
        resolve_set(1'b1, 1'b0, `BRANCH_BASE_PC, 32'h40, 32'h0, 32'hFFFF_FFF0);
        step();
        resolve_clr();
        check("nt_flush", {31'd0, flush}, 32'd0);
        check("nt_addr",  imem_addr, 32'h120);
        mem_resp(0, 32'hBBBB_0002);
        check("nt_ipc", instr_pc, 32'h120);
        resolve_set(1'b1, 1'b1, `BRANCH_BASE_PC, 32'h40, 32'h0, 32'hFFFF_FFF0);
        step();
        resolve_clr();
        check("tk_flush", {31'd0, flush}, 32'd1);
        check("tk_addr",  imem_addr, 32'h30);
        step();
        check("tk_flush_end", {31'd0, flush}, 32'd0);

        // JALR during an outstanding request with 3 wait states
        resolve_set(1'b0, 1'b0, `BRANCH_BASE_RS1, 32'h0, 32'h201, 32'h3);
        step();
        resolve_clr();
        check("jalr_flush", {31'd0, flush}, 32'd1);
        check("jalr_req",   {31'd0, imem_req}, 32'd1);
        check("jalr_stale", imem_addr, 32'h30);
        step();
        check("drain_stale", imem_addr, 32'h30);
        check("drain_flush", {31'd0, flush}, 32'd0);
        mem_resp(1, 32'hDEAD_BEEF);
        check("drain_valid", {31'd0, instr_valid}, 32'd0);
        check("drain_addr",  imem_addr, 32'h204);
        mem_resp(0, 32'hCCCC_0003);
        check("jalr_ipc", instr_pc, 32'h204);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        check("jalr_next", imem_addr, 32'h208);

        // redirect coinciding with ack: word discarded
        resolve_set(1'b0, 1'b0, `BRANCH_BASE_PC, 32'h300, 32'h0, 32'h10);
        imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        step();
        resolve_clr();
        imem_ack = 1'b0;
        check("ackr_flush", {31'd0, flush}, 32'd1);
        check("ackr_valid", {31'd0, instr_valid}, 32'd0);
        check("ackr_addr",  imem_addr, 32'h310);
        step();
        check("ackr_valid2", {31'd0, instr_valid}, 32'd0);

        // back-to-back redirects in DRAIN, second one via JALR with bit 0 cleared
        resolve_set(1'b0, 1'b0, `BRANCH_BASE_PC, 32'h400, 32'h0, 32'h0);
        step();
        resolve_set(1'b0, 1'b0, `BRANCH_BASE_RS1, 32'h0, 32'h501, 32'h8);
        step();
        resolve_clr();
        check("b2b_flush", {31'd0, flush}, 32'd1);
        check("b2b_stale", imem_addr, 32'h310);
        mem_resp(0, 32'hDEAD_0000);
        check("b2b_addr",  imem_addr, 32'h508);
        check("b2b_valid", {31'd0, instr_valid}, 32'd0);

        // misaligned JALR target
        resolve_set(1'b0, 1'b0, `BRANCH_BASE_RS1, 32'h0, 32'h100, 32'h2);
        step();
        resolve_clr();
        check("mis_set",   {31'd0, misalign}, 32'd1);
        check("mis_flush", {31'd0, flush}, 32'd0);
        check("mis_req",   {31'd0, imem_req}, 32'd0);
        resolve_set(1'b0, 1'b0, `BRANCH_BASE_PC, 32'h600, 32'h0, 32'h0);
        step();
        resolve_clr();
        step();
        check("halt_flush", {31'd0, flush}, 32'd0);
        check("halt_req",   {31'd0, imem_req}, 32'd0);
        check("halt_mis",   {31'd0, misalign}, 32'd1);

        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst2_mis", {31'd0, misalign}, 32'd0);
        check("rst2_req", {31'd0, imem_req}, 32'd0);
        step();
        check("rst2_req1", {31'd0, imem_req}, 32'd1);
        check("rst2_addr", imem_addr, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
